// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one working RAM, one decrypted RAM and one
// encrypted ROM among several requesting clients. A granted access drives the
// selected memory in the grant cycle; read returns come back through a
// fixed-latency pipeline tagged with the originating client.
//
// Handshake: a client holds req (with wren/sel/addr/data stable) until it sees
// its gnt bit in the same cycle; every granted cycle is one complete access and
// a request without gnt has no effect. Reads are answered RD_LATENCY cycles
// after their grant by a single-cycle rd_valid pulse for that client, with no
// back-pressure on the return path.
module mem_port_arbiter #(
  parameter int NUM_CLIENTS = 3,
  parameter int ADDR_W      = 8,
  parameter int ADDR_D_W    = 5,
  parameter int DATA_W      = 8,
  parameter int RD_LATENCY  = 1   // 1..3, must match the memories' read latency
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CLIENTS-1:0]        req,
  input  logic [NUM_CLIENTS-1:0]        req_wren,
  input  logic [2*NUM_CLIENTS-1:0]      req_sel,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] req_data,
  output logic [NUM_CLIENTS-1:0]        gnt,
  output logic [NUM_CLIENTS-1:0]        rd_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          err,
  output logic                          wren,
  output logic [ADDR_W-1:0]             address,
  output logic [DATA_W-1:0]             data,
  input  logic [DATA_W-1:0]             q,
  output logic                          wren_d,
  output logic [ADDR_D_W-1:0]           address_d,
  output logic [DATA_W-1:0]             data_d,
  input  logic [DATA_W-1:0]             q_d,
  output logic [ADDR_D_W-1:0]           address_m,
  input  logic [DATA_W-1:0]             q_m
);

  localparam int ID_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int LAST = RD_LATENCY - 1;

  localparam logic [1:0] SEL_WRAM = 2'd0;
  localparam logic [1:0] SEL_DRAM = 2'd1;
  localparam logic [1:0] SEL_EROM = 2'd2;

  // Priority pointer: the client searched first in the next cycle.
  logic [ID_W-1:0]   ptr;

  logic              found;
  logic [ID_W-1:0]   gnt_id;
  logic              gnt_any;

  // Per-client views of the flattened request buses.
  logic [1:0]        sel_a  [NUM_CLIENTS];
  logic [ADDR_W-1:0] addr_a [NUM_CLIENTS];
  logic [DATA_W-1:0] data_a [NUM_CLIENTS];

  // Fields of the winning client.
  logic              g_wren;
  logic [1:0]        g_sel;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  logic              illegal;
  logic              rd_accept;

  // Read-return pipeline: stage 0 is loaded in the grant cycle's clock edge.
  logic              pipe_valid [RD_LATENCY];
  logic [ID_W-1:0]   pipe_id    [RD_LATENCY];
  logic [1:0]        pipe_sel   [RD_LATENCY];

  // Unpack the per-client request slices.
  always_comb begin
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      sel_a[i]  = req_sel[2*i +: 2];
      addr_a[i] = req_addr[i*ADDR_W +: ADDR_W];
      data_a[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Round-robin search starting at ptr, wrapping once around the clients.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      int              idx;
      logic [ID_W-1:0] cand;
      idx = int'(ptr) + i;
      if (idx >= NUM_CLIENTS) idx = idx - NUM_CLIENTS;
      cand = ID_W'(idx);
      if (!found && req[cand]) begin
        found  = 1'b1;
        gnt_id = cand;
      end
    end
  end

  // Decode the winning access; nothing is granted while reset is held.
  always_comb begin
    gnt_any   = found & ~reset;
    g_wren    = req_wren[gnt_id];
    g_sel     = sel_a[gnt_id];
    g_addr    = addr_a[gnt_id];
    g_data    = data_a[gnt_id];
    // Writing the ROM or selecting the unused target is refused but still granted.
    illegal   = (g_sel == 2'd3) | ((g_sel == SEL_EROM) & g_wren);
    rd_accept = gnt_any & ~illegal & ~g_wren;
    err       = gnt_any & illegal;
    gnt       = gnt_any ? (NUM_CLIENTS'(1) << gnt_id) : '0;
  end

  // Steer the granted access onto exactly one memory port; idle ports stay at 0.
  always_comb begin
    wren      = 1'b0;
    address   = '0;
    data      = '0;
    wren_d    = 1'b0;
    address_d = '0;
    data_d    = '0;
    address_m = '0;
    if (gnt_any && !illegal) begin
      case (g_sel)
        SEL_WRAM: begin
          wren    = g_wren;
          address = g_addr;
          data    = g_data;
        end
        SEL_DRAM: begin
          wren_d    = g_wren;
          address_d = g_addr[ADDR_D_W-1:0];
          data_d    = g_data;
        end
        default: begin
          address_m = g_addr[ADDR_D_W-1:0];
        end
      endcase
    end
  end

  // Advance the priority pointer past whichever client was just served.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_id == ID_W'(NUM_CLIENTS - 1)) ? '0 : gnt_id + 1'b1;
    end
  end

  // Shift the read tags along; reset drops every read still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int s = 0; s < RD_LATENCY; s++) begin
        pipe_valid[s] <= 1'b0;
        pipe_id[s]    <= '0;
        pipe_sel[s]   <= '0;
      end
    end else begin
      pipe_valid[0] <= rd_accept;
      pipe_id[0]    <= gnt_id;
      pipe_sel[0]   <= g_sel;
      for (int s = 1; s < RD_LATENCY; s++) begin
        pipe_valid[s] <= pipe_valid[s-1];
        pipe_id[s]    <= pipe_id[s-1];
        pipe_sel[s]   <= pipe_sel[s-1];
      end
    end
  end

  // Return the memory output recorded for the oldest read; zero when idle.
  always_comb begin
    rd_valid = '0;
    rd_data  = '0;
    if (pipe_valid[LAST] && !reset) begin
      rd_valid = NUM_CLIENTS'(1) << pipe_id[LAST];
      case (pipe_sel[LAST])
        SEL_WRAM: rd_data = q;
        SEL_DRAM: rd_data = q_d;
        default:  rd_data = q_m;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (read latency 1 and 3) share the
// same client stimulus; each has its own memory models. Expected outputs come
// from a transaction-level model of the arbitration and memory contents.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic reset;
  logic [2:0]  req, req_wren;
  logic [5:0]  req_sel;
  logic [23:0] req_addr, req_data;

  logic [1:0][2:0] gnt_o, rdv_o;
  logic [1:0][7:0] rdd_o, addr_o, data_o, data_d_o;
  logic [1:0][4:0] addr_d_o, addr_m_o;
  logic [1:0]      err_o, wren_o, wren_d_o;
  logic [1:0][7:0] q_w, q_d, q_m;

  int checks = 0;
  int passed = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  mem_port_arbiter #(.RD_LATENCY(1)) u_lat1 (
    .clk(clk), .reset(reset), .req(req), .req_wren(req_wren), .req_sel(req_sel),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt_o[0]), .rd_valid(rdv_o[0]),
    .rd_data(rdd_o[0]), .err(err_o[0]), .wren(wren_o[0]), .address(addr_o[0]),
    .data(data_o[0]), .q(q_w[0]), .wren_d(wren_d_o[0]), .address_d(addr_d_o[0]),
    .data_d(data_d_o[0]), .q_d(q_d[0]), .address_m(addr_m_o[0]), .q_m(q_m[0])
  );

  mem_port_arbiter #(.RD_LATENCY(3)) u_lat3 (
    .clk(clk), .reset(reset), .req(req), .req_wren(req_wren), .req_sel(req_sel),
    .req_addr(req_addr), .req_data(req_data), .gnt(gnt_o[1]), .rd_valid(rdv_o[1]),
    .rd_data(rdd_o[1]), .err(err_o[1]), .wren(wren_o[1]), .address(addr_o[1]),
    .data(data_o[1]), .q(q_w[1]), .wren_d(wren_d_o[1]), .address_d(addr_d_o[1]),
    .data_d(data_d_o[1]), .q_d(q_d[1]), .address_m(addr_m_o[1]), .q_m(q_m[1])
  );

  // ---------------- memory contents ----------------
  function automatic logic [7:0] w_init(int i);
    return (i == 16) ? 8'hAB : 8'(i * 7 + 3);
  endfunction
  function automatic logic [7:0] d_init(int i);
    return 8'(i * 5 + 1);
  endfunction
  function automatic logic [7:0] rom_val(int i);
    return 8'(i * 29 + 200);
  endfunction

  // Memory models per instance, driven by that instance's ports.
  logic [7:0] env_w [2][256];
  logic [7:0] env_d [2][32];
  logic [7:0] qw_p  [2][3];
  logic [7:0] qd_p  [2][3];
  logic [7:0] qm_p  [2][3];
  logic       mem_ready = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [0:0] ki;
      ki = k[0];
      if (!mem_ready) begin
        for (int i = 0; i < 256; i++) env_w[ki][8'(i)] <= w_init(i);
        for (int i = 0; i < 32; i++)  env_d[ki][5'(i)] <= d_init(i);
      end else begin
        if (wren_o[ki])   env_w[ki][addr_o[ki]]   <= data_o[ki];
        if (wren_d_o[ki]) env_d[ki][addr_d_o[ki]] <= data_d_o[ki];
      end
      qw_p[ki][0] <= env_w[ki][addr_o[ki]];
      qd_p[ki][0] <= env_d[ki][addr_d_o[ki]];
      qm_p[ki][0] <= rom_val(int'(addr_m_o[ki]));
      for (int s = 1; s < 3; s++) begin
        qw_p[ki][2'(s)] <= qw_p[ki][2'(s - 1)];
        qd_p[ki][2'(s)] <= qd_p[ki][2'(s - 1)];
        qm_p[ki][2'(s)] <= qm_p[ki][2'(s - 1)];
      end
    end
    mem_ready <= 1'b1;
  end

  assign q_w[0] = qw_p[0][0];
  assign q_d[0] = qd_p[0][0];
  assign q_m[0] = qm_p[0][0];
  assign q_w[1] = qw_p[1][2];
  assign q_d[1] = qd_p[1][2];
  assign q_m[1] = qm_p[1][2];

  // ---------------- reference model ----------------
  int         m_ptr;
  int         cyc;
  logic [7:0] ref_w [256];
  logic [7:0] ref_d [32];
  // Entry: [31:16] cycle the return is due, [15:8] client, [7:0] data.
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  logic [2:0]      exp_gnt;
  logic            exp_err, exp_wren, exp_wren_d;
  logic [7:0]      exp_addr, exp_data, exp_data_d;
  logic [4:0]      exp_addr_d, exp_addr_m;
  logic [1:0][2:0] exp_rdv;
  logic [1:0][7:0] exp_rdd;

  function automatic int model_grant();
    if (reset) return -1;
    for (int i = 0; i < 3; i++) begin
      int c;
      c = (m_ptr + i) % 3;
      if (1'(req >> c)) return c;
    end
    return -1;
  endfunction

  // Expected outputs for the current cycle's inputs.
  task automatic model_expect();
    int g;
    logic wr;
    logic [1:0] sel;
    logic [7:0] a, d;
    g = model_grant();
    exp_gnt = '0; exp_err = 1'b0;
    exp_wren = 1'b0; exp_addr = '0; exp_data = '0;
    exp_wren_d = 1'b0; exp_addr_d = '0; exp_data_d = '0; exp_addr_m = '0;
    if (g >= 0) begin
      wr  = 1'(req_wren >> g);
      sel = 2'(req_sel >> (2 * g));
      a   = 8'(req_addr >> (8 * g));
      d   = 8'(req_data >> (8 * g));
      exp_gnt = 3'(1 << g);
      if (sel == 2'd3 || (sel == 2'd2 && wr)) exp_err = 1'b1;
      else if (sel == 2'd0) begin exp_wren = wr; exp_addr = a; exp_data = d; end
      else if (sel == 2'd1) begin exp_wren_d = wr; exp_addr_d = a[4:0]; exp_data_d = d; end
      else exp_addr_m = a[4:0];
    end
    exp_rdv = '0;
    exp_rdd = '0;
    if (!reset && exp_q0.size() > 0 && int'(exp_q0[0][31:16]) == cyc) begin
      exp_rdv[0] = 3'(1 << exp_q0[0][15:8]);
      exp_rdd[0] = exp_q0[0][7:0];
    end
    if (!reset && exp_q1.size() > 0 && int'(exp_q1[0][31:16]) == cyc) begin
      exp_rdv[1] = 3'(1 << exp_q1[0][15:8]);
      exp_rdd[1] = exp_q1[0][7:0];
    end
  endtask

  // Apply this cycle's effects to the model state.
  task automatic model_commit();
    int g;
    logic wr;
    logic [1:0] sel;
    logic [7:0] a, d, v;
    if (reset) begin
      m_ptr = 0;
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      if (exp_q0.size() > 0 && int'(exp_q0[0][31:16]) == cyc) void'(exp_q0.pop_front());
      if (exp_q1.size() > 0 && int'(exp_q1[0][31:16]) == cyc) void'(exp_q1.pop_front());
      g = model_grant();
      if (g >= 0) begin
        m_ptr = (g + 1) % 3;
        wr  = 1'(req_wren >> g);
        sel = 2'(req_sel >> (2 * g));
        a   = 8'(req_addr >> (8 * g));
        d   = 8'(req_data >> (8 * g));
        if (!(sel == 2'd3 || (sel == 2'd2 && wr))) begin
          if (wr) begin
            if (sel == 2'd0) ref_w[a] = d;
            else ref_d[a[4:0]] = d;
          end else begin
            v = (sel == 2'd0) ? ref_w[a] : (sel == 2'd1) ? ref_d[a[4:0]] : rom_val(int'(a[4:0]));
            exp_q0.push_back({16'(cyc + 1), 8'(g), v});
            exp_q1.push_back({16'(cyc + 3), 8'(g), v});
          end
        end
      end
    end
    cyc++;
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    req = '0; req_wren = '0; req_sel = '0; req_addr = '0; req_data = '0;
  endtask

  task automatic set_client(int k, logic wr, logic [1:0] sel, logic [7:0] a, logic [7:0] d);
    req      = req | 3'(1 << k);
    req_wren = (req_wren & ~3'(1 << k)) | (wr ? 3'(1 << k) : 3'b000);
    req_sel  = (req_sel & ~(6'd3 << (2 * k))) | (6'(sel) << (2 * k));
    req_addr = (req_addr & ~(24'hFF << (8 * k))) | (24'(a) << (8 * k));
    req_data = (req_data & ~(24'hFF << (8 * k))) | (24'(d) << (8 * k));
  endtask

  task automatic drop_client(int k);
    req = req & ~3'(1 << k);
  endtask

  // Move to the sampling point of the current cycle.
  task automatic step();
    @(negedge clk);
    model_expect();
  endtask

  // Close the current cycle and move just past the next active edge.
  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(int n);
    reset = 1'b1;
    idle_inputs();
    repeat (n) begin step(); advance(); end
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      req = 3'($urandom); req_wren = 3'($urandom); req_sel = 6'($urandom);
      req_addr = 24'($urandom); req_data = 24'($urandom);
      step();
      for (int k = 0; k < 2; k++) begin
        logic [0:0] ki;
        ki = k[0];
        checks++;
        if ({gnt_o[ki], rdv_o[ki], rdd_o[ki], err_o[ki], wren_o[ki], addr_o[ki], data_o[ki],
             wren_d_o[ki], addr_d_o[ki], data_d_o[ki], addr_m_o[ki]} !== '0)
          $display("FAIL reset_outputs u%0d cyc=%0d got gnt=%b rdv=%b rdd=%h err=%b wren=%b addr=%h wren_d=%b addr_d=%h addr_m=%h, all must be 0",
                   k, cyc, gnt_o[ki], rdv_o[ki], rdd_o[ki], err_o[ki], wren_o[ki], addr_o[ki],
                   wren_d_o[ki], addr_d_o[ki], addr_m_o[ki]);
        else passed++;
      end
      advance();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  task automatic test_single_read();
    apply_reset(2);
    set_client(0, 1'b0, 2'd0, 8'h10, 8'h00);
    step();
    checks++;
    if (gnt_o[0] !== 3'b001 || addr_o[0] !== 8'h10 || wren_o[0] !== 1'b0)
      $display("FAIL single_read_grant got gnt=%b addr=%h wren=%b exp gnt=001 addr=10 wren=0", gnt_o[0], addr_o[0], wren_o[0]);
    else passed++;
    advance();
    idle_inputs();
    step();
    checks++;
    if (rdv_o[0] !== 3'b001 || rdd_o[0] !== 8'hAB)
      $display("FAIL single_read_ret1 got rdv=%b rdd=%h exp rdv=001 rdd=ab", rdv_o[0], rdd_o[0]);
    else passed++;
    checks++;
    if (rdv_o[1] !== 3'b000)
      $display("FAIL single_read_early3 got rdv=%b exp 000", rdv_o[1]);
    else passed++;
    advance();
    step(); advance();
    step();
    checks++;
    if (rdv_o[1] !== 3'b001 || rdd_o[1] !== 8'hAB || rdv_o[0] !== 3'b000)
      $display("FAIL single_read_ret3 got rdv3=%b rdd3=%h rdv1=%b exp 001 ab 000", rdv_o[1], rdd_o[1], rdv_o[0]);
    else passed++;
    advance();
  endtask

  task automatic test_round_robin();
    logic [2:0] rr_seq [6];
    rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    apply_reset(2);
    for (int k = 0; k < 3; k++) set_client(k, 1'b0, 2'd0, 8'(k), 8'h00);
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (gnt_o[0] !== rr_seq[3'(i)] || gnt_o[1] !== rr_seq[3'(i)])
        $display("FAIL round_robin step=%0d got %b/%b exp %b", i, gnt_o[0], gnt_o[1], rr_seq[3'(i)]);
      else passed++;
      advance();
    end
    idle_inputs();
    repeat (4) begin step(); advance(); end
  endtask

  task automatic test_dram_write();
    apply_reset(2);
    set_client(2, 1'b1, 2'd1, 8'h1F, 8'h5C);
    step();
    checks++;
    if (gnt_o[0] !== 3'b100 || wren_d_o[0] !== 1'b1 || addr_d_o[0] !== 5'h1F ||
        data_d_o[0] !== 8'h5C || wren_o[0] !== 1'b0)
      $display("FAIL dram_write got gnt=%b wren_d=%b addr_d=%h data_d=%h wren=%b exp 100 1 1f 5c 0",
               gnt_o[0], wren_d_o[0], addr_d_o[0], data_d_o[0], wren_o[0]);
    else passed++;
    advance();
    idle_inputs();
    repeat (4) begin
      step();
      checks++;
      if (rdv_o[0] !== 3'b000 || rdv_o[1] !== 3'b000)
        $display("FAIL dram_write_no_ret got rdv=%b/%b exp 000", rdv_o[0], rdv_o[1]);
      else passed++;
      advance();
    end
    set_client(0, 1'b0, 2'd1, 8'h1F, 8'h00);
    step(); advance();
    idle_inputs();
    step();
    checks++;
    if (rdv_o[0] !== 3'b001 || rdd_o[0] !== 8'h5C)
      $display("FAIL dram_readback got rdv=%b rdd=%h exp 001 5c", rdv_o[0], rdd_o[0]);
    else passed++;
    advance();
    repeat (3) begin step(); advance(); end
  endtask

  task automatic test_illegal();
    apply_reset(2);
    for (int i = 0; i < 2; i++) begin
      if (i == 0) set_client(1, 1'b1, 2'd2, 8'h03, 8'h77);
      else        set_client(1, 1'b0, 2'd3, 8'h04, 8'h00);
      step();
      for (int k = 0; k < 2; k++) begin
        logic [0:0] ki;
        ki = k[0];
        checks++;
        if (gnt_o[ki] !== 3'b010 || err_o[ki] !== 1'b1 || wren_o[ki] !== 1'b0 || wren_d_o[ki] !== 1'b0)
          $display("FAIL illegal_access u%0d step=%0d got gnt=%b err=%b wren=%b wren_d=%b exp 010 1 0 0",
                   k, i, gnt_o[ki], err_o[ki], wren_o[ki], wren_d_o[ki]);
        else passed++;
      end
      advance();
    end
    idle_inputs();
    repeat (4) begin
      step();
      checks++;
      if (rdv_o !== '0 || err_o !== 2'b00)
        $display("FAIL illegal_no_ret got rdv=%b/%b err=%b exp 000 0", rdv_o[0], rdv_o[1], err_o);
      else passed++;
      advance();
    end
  endtask

  task automatic test_lat3_reset();
    apply_reset(2);
    set_client(0, 1'b0, 2'd2, 8'h21, 8'h00);
    set_client(1, 1'b0, 2'd2, 8'h05, 8'h00);
    set_client(2, 1'b0, 2'd2, 8'h1E, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (gnt_o[1] !== 3'(1 << i))
        $display("FAIL lat3_grant step=%0d got %b exp %b", i, gnt_o[1], 3'(1 << i));
      else passed++;
      advance();
      drop_client(i);
    end
    // Client 0 keeps the arbiter busy so the pointer moves away from 0.
    set_client(0, 1'b1, 2'd0, 8'h80, 8'h11);
    step();
    checks++;
    if (rdv_o[1] !== 3'b001 || rdd_o[1] !== rom_val(1))
      $display("FAIL lat3_ret0 got rdv=%b rdd=%h exp 001 %h", rdv_o[1], rdd_o[1], rom_val(1));
    else passed++;
    advance();
    step();
    checks++;
    if (rdv_o[1] !== 3'b010 || rdd_o[1] !== rom_val(5))
      $display("FAIL lat3_ret1 got rdv=%b rdd=%h exp 010 %h", rdv_o[1], rdd_o[1], rom_val(5));
    else passed++;
    advance();
    reset = 1'b1;
    idle_inputs();
    step();
    checks++;
    if (rdv_o[1] !== 3'b000 || gnt_o[1] !== 3'b000)
      $display("FAIL lat3_ret2_in_reset got rdv=%b gnt=%b exp 000 000", rdv_o[1], gnt_o[1]);
    else passed++;
    advance();
    reset = 1'b0;
    set_client(0, 1'b0, 2'd0, 8'h01, 8'h00);
    set_client(1, 1'b0, 2'd0, 8'h02, 8'h00);
    step();
    checks++;
    if (gnt_o[1] !== 3'b001 || rdv_o[1] !== 3'b000)
      $display("FAIL lat3_ptr_after_reset got gnt=%b rdv=%b exp 001 000", gnt_o[1], rdv_o[1]);
    else passed++;
    advance();
    idle_inputs();
    step();
    checks++;
    if (rdv_o[1] !== 3'b000)
      $display("FAIL lat3_no_stale_ret got rdv=%b exp 000", rdv_o[1]);
    else passed++;
    advance();
    repeat (4) begin step(); advance(); end
  endtask

  task automatic test_random();
    apply_reset(2);
    for (int c = 0; c < 600; c++) begin
      int r;
      reset = (c < 590) && ($urandom_range(0, 59) == 0);
      idle_inputs();
      if (c < 590) begin
        for (int k = 0; k < 3; k++) begin
          logic [1:0] sel;
          logic [7:0] a;
          if ($urandom_range(0, 3) != 0) begin
            r   = $urandom_range(0, 9);
            sel = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            a   = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            set_client(k, ($urandom_range(0, 2) == 0), sel, a, 8'($urandom));
          end
        end
      end
      step();
      for (int k = 0; k < 2; k++) begin
        logic [0:0] ki;
        ki = k[0];
        checks++;
        if (gnt_o[ki] !== exp_gnt) $display("FAIL rnd_gnt u%0d cyc=%0d got %b exp %b", k, cyc, gnt_o[ki], exp_gnt);
        else passed++;
        checks++;
        if (err_o[ki] !== exp_err) $display("FAIL rnd_err u%0d cyc=%0d got %b exp %b", k, cyc, err_o[ki], exp_err);
        else passed++;
        checks++;
        if ({wren_o[ki], addr_o[ki], data_o[ki]} !== {exp_wren, exp_addr, exp_data})
          $display("FAIL rnd_wram u%0d cyc=%0d got %b/%h/%h exp %b/%h/%h", k, cyc,
                   wren_o[ki], addr_o[ki], data_o[ki], exp_wren, exp_addr, exp_data);
        else passed++;
        checks++;
        if ({wren_d_o[ki], addr_d_o[ki], data_d_o[ki]} !== {exp_wren_d, exp_addr_d, exp_data_d})
          $display("FAIL rnd_dram u%0d cyc=%0d got %b/%h/%h exp %b/%h/%h", k, cyc,
                   wren_d_o[ki], addr_d_o[ki], data_d_o[ki], exp_wren_d, exp_addr_d, exp_data_d);
        else passed++;
        checks++;
        if (addr_m_o[ki] !== exp_addr_m) $display("FAIL rnd_rom_addr u%0d cyc=%0d got %h exp %h", k, cyc, addr_m_o[ki], exp_addr_m);
        else passed++;
        checks++;
        if (rdv_o[ki] !== exp_rdv[ki]) $display("FAIL rnd_rd_valid u%0d cyc=%0d got %b exp %b", k, cyc, rdv_o[ki], exp_rdv[ki]);
        else passed++;
        checks++;
        if (rdd_o[ki] !== exp_rdd[ki]) $display("FAIL rnd_rd_data u%0d cyc=%0d got %h exp %h", k, cyc, rdd_o[ki], exp_rdd[ki]);
        else passed++;
      end
      advance();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    idle_inputs();
    m_ptr = 0;
    cyc   = 0;
    for (int i = 0; i < 256; i++) ref_w[8'(i)] = w_init(i);
    for (int i = 0; i < 32; i++)  ref_d[5'(i)] = d_init(i);
    test_reset();
    test_single_read();
    test_round_robin();
    test_dram_write();
    test_illegal();
    test_lat3_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
